// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-ROM request port
// and produces the registered IF/ID payload (if_pc, if_inst, if_valid).
//  state | meaning
//  IDLE  | out of reset, no request outstanding
//  REQ   | rom_req high at pc_q, waiting for rom_ack
//  HOLD  | word acked under stall, parked in buf_inst until release
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  input  logic [31:0] exc_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_rdata,
  output logic        fetch_busy,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] buf_inst;
  logic [31:0] flush_pc;
  logic        flush_pend;
  logic [31:0] next_pc;
  logic [31:0] redirect_pc;

  // Branches only choose the successor PC; the in-flight fetch is the delay slot.
  assign next_pc     = branch_flag ? branch_addr : pc_q + 32'd4;
  assign redirect_pc = flush ? exc_pc : flush_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush || !stall_pc) state_d = REQ;
      REQ:     if (rom_ack && !flush && !flush_pend && stall_pc) state_d = HOLD;
      HOLD:    if (flush || !stall_pc) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rom_req    = (state_q == REQ);
    rom_addr   = pc_q;
    fetch_busy = rom_req & ~rom_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      buf_inst   <= 32'd0;
      flush_pend <= 1'b0;
      flush_pc   <= 32'd0;
      if_pc      <= 32'd0;
      if_inst    <= 32'd0;
      if_valid   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) pc_q <= exc_pc;
        end
        REQ: begin
          if (!rom_ack) begin
            // Address must stay stable until ack, so remember the redirect.
            if (flush) begin
              flush_pend <= 1'b1;
              flush_pc   <= exc_pc;
              if_valid   <= 1'b0;
            end
          end else if (flush || flush_pend) begin
            pc_q       <= redirect_pc;
            if_valid   <= 1'b0;
            flush_pend <= 1'b0;
          end else if (stall_pc) begin
            buf_inst <= rom_rdata;
          end else begin
            if_inst  <= rom_rdata;
            if_pc    <= pc_q;
            if_valid <= 1'b1;
            pc_q     <= next_pc;
          end
        end
        HOLD: begin
          if (flush) begin
            if_valid <= 1'b0;
            pc_q     <= exc_pc;
          end else if (!stall_pc) begin
            if_inst  <= buf_inst;
            if_pc    <= pc_q;
            if_valid <= 1'b1;
            pc_q     <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
